// File: rtl/atomic_counter_arbiter.sv
// Round-robin arbiter sharing the two-beat read port of a 64-bit atomic counter.
// Each grant issues an LSB/snapshot beat then an MSB beat and returns a coherent {msb,lsb}.
module atomic_counter_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATABUS     = 32,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     rd_req_i,
  output logic [NUM_REQ-1:0]     rd_done_o,
  output logic [2*DATABUS-1:0]   rd_data_o,
  output logic                   rd_err_o,
  output logic                   busy_o,
  output logic                   ctr_req_o,
  output logic                   ctr_atomic_o,
  input  logic                   ctr_ack_i,
  input  logic [DATABUS-1:0]     ctr_data_i
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned TmoW = 8;
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(ACK_TIMEOUT);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    StIdle,
    StReqLsb,
    StWaitLsb,
    StReqMsb,
    StWaitMsb,
    StDone
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [IdxW-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [IdxW-1:0]     r_gnt_idx, w_gnt_idx_nxt;
  logic [IdxW-1:0]     w_pick;
  logic                w_any;
  logic [DATABUS-1:0]  r_lsb, w_lsb_nxt;
  logic [DATABUS-1:0]  r_msb, w_msb_nxt;
  logic                r_err, w_err_nxt;
  logic [TmoW-1:0]     r_tmo, w_tmo_nxt;

  // First set request at or after the round-robin pointer, wrapping.
  always_comb begin
    int unsigned w_idx;
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = (32'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_any && rd_req_i[IdxW'(w_idx)]) begin
        w_any  = 1'b1;
        w_pick = IdxW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
      r_lsb     <= '0;
      r_msb     <= '0;
      r_err     <= 1'b0;
      r_tmo     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_lsb     <= w_lsb_nxt;
      r_msb     <= w_msb_nxt;
      r_err     <= w_err_nxt;
      r_tmo     <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_gnt_idx_nxt = r_gnt_idx;
    w_lsb_nxt     = r_lsb;
    w_msb_nxt     = r_msb;
    w_err_nxt     = r_err;
    w_tmo_nxt     = r_tmo;
    case (r_state)
      StIdle: begin
        if (w_any) begin
          w_gnt_idx_nxt = w_pick;
          w_state_nxt   = StReqLsb;
        end
      end
      StReqLsb: begin
        w_tmo_nxt   = '0;
        w_state_nxt = StWaitLsb;
      end
      StWaitLsb: begin
        if (ctr_ack_i) begin
          w_lsb_nxt   = ctr_data_i;
          w_state_nxt = StReqMsb;
        end else if (r_tmo == TmoLimit) begin
          // Abort skips the MSB beat entirely.
          w_err_nxt   = 1'b1;
          w_state_nxt = StDone;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      StReqMsb: begin
        w_tmo_nxt   = '0;
        w_state_nxt = StWaitMsb;
      end
      StWaitMsb: begin
        if (ctr_ack_i) begin
          w_msb_nxt   = ctr_data_i;
          w_state_nxt = StDone;
        end else if (r_tmo == TmoLimit) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StDone;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      StDone: begin
        w_rr_ptr_nxt = (r_gnt_idx == LastIdx) ? '0 : r_gnt_idx + 1'b1;
        w_err_nxt    = 1'b0;
        w_state_nxt  = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    rd_done_o    = '0;
    rd_data_o    = '0;
    rd_err_o     = 1'b0;
    busy_o       = (r_state != StIdle);
    ctr_req_o    = 1'b0;
    ctr_atomic_o = 1'b0;
    case (r_state)
      StReqLsb: begin
        ctr_req_o    = 1'b1;
        ctr_atomic_o = 1'b1;
      end
      StReqMsb: ctr_req_o = 1'b1;
      StDone: begin
        rd_done_o[r_gnt_idx] = 1'b1;
        rd_err_o             = r_err;
        if (!r_err) rd_data_o = {r_msb, r_lsb};
      end
      default: ;
    endcase
  end

endmodule
